// File: rtl/dsp_mac_sequencer.sv
// Job-level controller for one DSP slice: streams a job's operand beats into
// the slice accumulator, waits out the slice pipeline, and returns the sum.
module dsp_mac_sequencer #(
  parameter int LEN_W   = 8,
  parameter int DSP_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             job_mode,
  input  logic             job_sub,
  input  logic             job_loadconst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [115:0]     in_data,
  output logic [115:0]     dsp_stream,
  output logic             dsp_loadconst,
  output logic             dsp_accumulate,
  output logic             dsp_mode,
  output logic             dsp_sub,
  output logic             dsp_negate,
  output logic             dsp_mux9_select,
  output logic             dsp_internal_coeffa,
  output logic             dsp_internal_coeffb,
  input  logic [63:0]      dsp_resulta,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic             busy
);

  localparam int DRAIN_W = $clog2(DSP_LAT + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]         state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   count;
  logic [DRAIN_W-1:0] drain;
  logic               seeded;  // accumulator already holds a valid partial sum

  assign dsp_negate          = 1'b0;
  assign dsp_mux9_select     = 1'b1;
  assign dsp_internal_coeffa = 1'b0;
  assign dsp_internal_coeffb = 1'b0;

  assign job_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign in_ready  = (state == STREAM) && (count != len_q);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      len_q          <= '0;
      count          <= '0;
      drain          <= '0;
      seeded         <= 1'b0;
      dsp_stream     <= '0;
      dsp_loadconst  <= 1'b0;
      dsp_accumulate <= 1'b0;
      dsp_mode       <= 1'b0;
      dsp_sub        <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= '0;
    end else begin
      // Default beat is HOLD: zero product added to an unchanged accumulator.
      dsp_stream     <= '0;
      dsp_loadconst  <= 1'b0;
      dsp_accumulate <= 1'b1;
      case (state)
        IDLE: begin
          dsp_accumulate <= 1'b0;  // CLEAR
          if (job_valid) begin
            len_q    <= job_len;
            dsp_mode <= job_mode;
            dsp_sub  <= job_sub;
            count    <= '0;
            seeded   <= 1'b0;
            state    <= job_loadconst ? LOAD : STREAM;
          end
        end
        LOAD: begin
          dsp_loadconst  <= 1'b1;
          dsp_accumulate <= 1'b0;
          seeded         <= 1'b1;
          state          <= STREAM;
        end
        STREAM: begin
          if (count == len_q) begin
            drain <= DRAIN_W'(DSP_LAT);
            state <= DRAIN;
          end else if (in_valid) begin
            dsp_stream     <= in_data;
            dsp_accumulate <= seeded;
            seeded         <= 1'b1;
            count          <= count + LEN_W'(1);
            if (count + LEN_W'(1) == len_q) begin
              drain <= DRAIN_W'(DSP_LAT);
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain == '0) begin
            res_data  <= dsp_resulta;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            drain <= drain - DRAIN_W'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
